fm_guard_ctrl_issuer: RTL and testbench

- Initiator side of the fm_guard_gen control handshake (ctrl_valid/ctrl_ready/ctrl_finish plus layer config fields).
- Queues layer descriptors from the layer scheduler and issues them one at a time to the guard-gen control port.
- Waits for each layer's ctrl_finish before issuing the next, and supervises completion with a timeout.
- Sits between the top-level layer sequencer and fm_guard_gen_ctrl.

---
 rtl/fm_guard_ctrl_issuer.sv | 210 +++++++++++++++++++++
 tb/tb_fm_guard_ctrl_issuer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fm_guard_ctrl_issuer.sv
// rtl/fm_guard_ctrl_issuer.sv - queues layer descriptors and issues them to the guard-gen control port
//
// Purpose: initiator side of the fm_guard_gen control handshake. Layer
// descriptors are buffered in a small FIFO and issued one at a time; the next
// layer is only offered after ctrl_finish of the current one. A completion
// watchdog flags layers that take longer than TIMEOUT cycles.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   desc_valid/desc_ready     descriptor push handshake
//   desc_w/h/c, desc_kernal_mode, desc_bit_mode   descriptor fields
//   abort                     flush queue, clear errors, return to IDLE
//   ctrl_valid/ctrl_ready     config handshake towards guard-gen
//   ctrl_finish               layer-complete pulse from guard-gen
//   w_num_o/h_num_o/c_num_o, kernal_mode_o, bit_mode_o   issued config
//   busy, layer_done, layer_cnt, fifo_level              status
//   timeout_err, cfg_err      sticky error flags
module fm_guard_ctrl_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       desc_valid,
  output logic                       desc_ready,
  input  logic [7:0]                 desc_w,
  input  logic [7:0]                 desc_h,
  input  logic [7:0]                 desc_c,
  input  logic                       desc_kernal_mode,
  input  logic                       desc_bit_mode,
  input  logic                       abort,
  output logic                       ctrl_valid,
  input  logic                       ctrl_ready,
  input  logic                       ctrl_finish,
  output logic [7:0]                 w_num_o,
  output logic [7:0]                 h_num_o,
  output logic [7:0]                 c_num_o,
  output logic                       kernal_mode_o,
  output logic                       bit_mode_o,
  output logic                       busy,
  output logic                       layer_done,
  output logic [CNT_W-1:0]           layer_cnt,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       timeout_err,
  output logic                       cfg_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  typedef struct packed {
    logic [7:0] w;
    logic [7:0] h;
    logic [7:0] c;
    logic       k;
    logic       b;
  } desc_t;

  desc_t            mem_q [DEPTH];
  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             first_q, first_d;
  desc_t            out_q, out_d;
  logic             ctrl_valid_q, ctrl_valid_d;
  logic             layer_done_q, layer_done_d;
  logic [CNT_W-1:0] layer_cnt_q, layer_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             cfg_err_q, cfg_err_d;
  logic             push, pop, accept;
  desc_t            head, desc_in;

  assign desc_ready = (count_q != LW'(DEPTH));
  assign accept     = desc_valid && desc_ready;
  assign head       = mem_q[rd_ptr_q];
  assign desc_in    = '{w: desc_w, h: desc_h, c: desc_c, k: desc_kernal_mode, b: desc_bit_mode};

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    tcnt_d        = tcnt_q;
    first_d       = first_q;
    out_d         = out_q;
    ctrl_valid_d  = ctrl_valid_q;
    layer_done_d  = 1'b0;
    layer_cnt_d   = layer_cnt_q;
    timeout_err_d = timeout_err_q;
    cfg_err_d     = cfg_err_q;
    pop           = 1'b0;
    // c_num of 0xFF would overflow the receiver's c_num+1: consume but drop.
    push          = accept && (desc_c != 8'hFF);
    if (accept && (desc_c == 8'hFF)) cfg_err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop          = 1'b1;
          out_d        = head;
          ctrl_valid_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ctrl_ready) begin
          ctrl_valid_d = 1'b0;
          tcnt_d       = '0;
          first_d      = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        first_d = 1'b0;
        if (tcnt_q != TW'(TIMEOUT)) begin
          tcnt_d = tcnt_q + TW'(1);
          if (tcnt_q + TW'(1) == TW'(TIMEOUT)) timeout_err_d = 1'b1;
        end
        // The receiver's finish is stale in the first cycle after handshake.
        if (!first_q && ctrl_finish) begin
          layer_done_d = 1'b1;
          layer_cnt_d  = layer_cnt_q + CNT_W'(1);
          if (count_q != '0) begin
            pop          = 1'b1;
            out_d        = head;
            ctrl_valid_d = 1'b1;
            state_d      = S_ISSUE;
          end else begin
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + LW'(push) - LW'(pop);

    if (abort) begin
      push          = 1'b0;
      state_d       = S_IDLE;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      tcnt_d        = '0;
      first_d       = 1'b0;
      out_d         = out_q;
      ctrl_valid_d  = 1'b0;
      layer_done_d  = 1'b0;
      layer_cnt_d   = layer_cnt_q;
      timeout_err_d = 1'b0;
      cfg_err_d     = 1'b0;
    end
  end

  // Storage array has no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= desc_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tcnt_q        <= '0;
      first_q       <= 1'b0;
      out_q         <= '0;
      ctrl_valid_q  <= 1'b0;
      layer_done_q  <= 1'b0;
      layer_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tcnt_q        <= tcnt_d;
      first_q       <= first_d;
      out_q         <= out_d;
      ctrl_valid_q  <= ctrl_valid_d;
      layer_done_q  <= layer_done_d;
      layer_cnt_q   <= layer_cnt_d;
      timeout_err_q <= timeout_err_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign ctrl_valid    = ctrl_valid_q;
  assign w_num_o       = out_q.w;
  assign h_num_o       = out_q.h;
  assign c_num_o       = out_q.c;
  assign kernal_mode_o = out_q.k;
  assign bit_mode_o    = out_q.b;
  assign busy          = (state_q != S_IDLE) || (count_q != '0);
  assign layer_done    = layer_done_q;
  assign layer_cnt     = layer_cnt_q;
  assign fifo_level    = count_q;
  assign timeout_err   = timeout_err_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_fm_guard_ctrl_issuer.sv
// tb/tb_fm_guard_ctrl_issuer.sv - directed self-checking bench for fm_guard_ctrl_issuer
module tb_fm_guard_ctrl_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        desc_valid, desc_ready;
  logic [7:0]  desc_w, desc_h, desc_c;
  logic        desc_kernal_mode, desc_bit_mode;
  logic        abort;
  logic        ctrl_valid, ctrl_ready, ctrl_finish;
  logic [7:0]  w_num_o, h_num_o, c_num_o;
  logic        kernal_mode_o, bit_mode_o;
  logic        busy, layer_done;
  logic [15:0] layer_cnt;
  logic [2:0]  fifo_level;
  logic        timeout_err, cfg_err;

  int errors = 0;
  int checks = 0;

  fm_guard_ctrl_issuer #(.DEPTH(4), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_w(desc_w), .desc_h(desc_h), .desc_c(desc_c),
    .desc_kernal_mode(desc_kernal_mode), .desc_bit_mode(desc_bit_mode),
    .abort(abort),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_finish(ctrl_finish),
    .w_num_o(w_num_o), .h_num_o(h_num_o), .c_num_o(c_num_o),
    .kernal_mode_o(kernal_mode_o), .bit_mode_o(bit_mode_o),
    .busy(busy), .layer_done(layer_done), .layer_cnt(layer_cnt),
    .fifo_level(fifo_level), .timeout_err(timeout_err), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_desc(input logic [7:0] w, input logic [7:0] h, input logic [7:0] c,
                          input logic k, input logic b);
    desc_valid = 1'b1; desc_w = w; desc_h = h; desc_c = c;
    desc_kernal_mode = k; desc_bit_mode = b;
  endtask

  initial begin
    rst = 1'b1; desc_valid = 0; desc_w = 0; desc_h = 0; desc_c = 0;
    desc_kernal_mode = 0; desc_bit_mode = 0; abort = 0;
    ctrl_ready = 0; ctrl_finish = 0;
    tick(); tick();
    chk("rst_desc_ready", desc_ready, 1);
    chk("rst_ctrl_valid", ctrl_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_layer_cnt", layer_cnt, 0);
    chk("rst_errs", {timeout_err, cfg_err, layer_done}, 0);
    rst = 1'b0;
    tick();

    // Single layer, ready held high.
    ctrl_ready = 1;
    set_desc(8'd3, 8'd2, 8'd1, 1'b1, 1'b0);
    tick(); desc_valid = 0;
    chk("t1_level_after_push", fifo_level, 1);
    chk("t1_valid_not_yet", ctrl_valid, 0);
    tick();
    chk("t1_valid_rise", ctrl_valid, 1);
    chk("t1_fields", {w_num_o, h_num_o, c_num_o, kernal_mode_o, bit_mode_o}, {8'd3, 8'd2, 8'd1, 1'b1, 1'b0});
    tick();
    chk("t1_valid_drop_after_hs", ctrl_valid, 0);
    repeat (4) tick();
    ctrl_finish = 1;
    tick(); ctrl_finish = 0;
    chk("t1_layer_done", layer_done, 1);
    chk("t1_layer_cnt", layer_cnt, 1);
    chk("t1_busy", busy, 0);
    tick();
    chk("t1_done_pulse_end", layer_done, 0);
    chk("t1_w_retained", w_num_o, 3);

    // Stale finish: held high through IDLE, ISSUE and the blanking cycle.
    ctrl_finish = 1;
    tick(); tick();
    chk("t2_idle_no_done", layer_done, 0);
    set_desc(8'd5, 8'd6, 8'd7, 1'b0, 1'b1);
    tick(); desc_valid = 0;
    tick();
    chk("t2_issue", {ctrl_valid, layer_done}, 2'b10);
    tick();
    chk("t2_hs_no_done", {ctrl_valid, layer_done}, 2'b00);
    tick();
    chk("t2_blank_no_done", layer_done, 0);
    tick(); ctrl_finish = 0;
    chk("t2_done_second_wait", layer_done, 1);
    chk("t2_layer_cnt", layer_cnt, 2);

    // Back-to-back with full FIFO and timeout while D0 is outstanding.
    set_desc(8'h10, 8'h11, 8'h12, 1'b0, 1'b0);
    tick(); desc_valid = 0;
    tick();
    chk("t3_d0_issue", {ctrl_valid, w_num_o}, {1'b1, 8'h10});
    tick();
    for (int k = 1; k <= 4; k++) begin
      set_desc(8'h20 + 8'(k), 8'h30 + 8'(k), 8'h40 + 8'(k), k[0], k[1]);
      tick();
    end
    desc_valid = 0;
    chk("t3_full_level", fifo_level, 4);
    chk("t3_full_not_ready", desc_ready, 0);
    set_desc(8'h55, 8'h55, 8'h55, 1'b1, 1'b1);
    tick(); desc_valid = 0;
    chk("t3_refused_level", fifo_level, 4);
    chk("t3_no_timeout_5", timeout_err, 0);
    tick(); tick();
    chk("t3_no_timeout_7", timeout_err, 0);
    tick();
    chk("t3_timeout_8", timeout_err, 1);
    ctrl_finish = 1;
    tick(); ctrl_finish = 0;
    chk("t3_d0_done_after_timeout", {layer_done, layer_cnt}, {1'b1, 16'd3});
    chk("t3_timeout_sticky", timeout_err, 1);
    chk("t3_level_after_pop", fifo_level, 3);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t3_issue_d%0d", k),
          {ctrl_valid, w_num_o, h_num_o, c_num_o, kernal_mode_o, bit_mode_o},
          {1'b1, 8'h20 + 8'(k), 8'h30 + 8'(k), 8'h40 + 8'(k), k[0], k[1]});
      tick();
      chk($sformatf("t3_hs_d%0d", k), ctrl_valid, 0);
      tick();
      ctrl_finish = 1;
      tick(); ctrl_finish = 0;
      chk($sformatf("t3_done_d%0d", k), {layer_done, layer_cnt}, {1'b1, 16'(3 + k)});
    end
    chk("t3_end_idle", {ctrl_valid, busy}, 2'b00);

    // Backpressure: ready low for 10 cycles.
    ctrl_ready = 0;
    set_desc(8'd7, 8'd8, 8'd9, 1'b1, 1'b1);
    tick(); desc_valid = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t4_hold_%0d", i),
          {ctrl_valid, w_num_o, h_num_o, c_num_o, kernal_mode_o, bit_mode_o},
          {1'b1, 8'd7, 8'd8, 8'd9, 1'b1, 1'b1});
      tick();
    end
    ctrl_ready = 1;
    tick();
    chk("t4_hs_on_ready", ctrl_valid, 0);
    tick();
    ctrl_finish = 1;
    tick(); ctrl_finish = 0;
    chk("t4_done", {layer_done, layer_cnt}, {1'b1, 16'd8});

    // Config error: c=0xFF consumed but not queued.
    set_desc(8'd1, 8'd1, 8'hFF, 1'b0, 1'b0);
    tick(); desc_valid = 0;
    chk("t5_cfg_err", cfg_err, 1);
    chk("t5_level", fifo_level, 0);
    tick();
    chk("t5_no_issue", {ctrl_valid, busy}, 2'b00);

    // Abort during ISSUE with two queued; timeout_err is still set from t3.
    ctrl_ready = 0;
    for (int k = 0; k < 3; k++) begin
      set_desc(8'h60 + 8'(k), 8'h01, 8'h02, 1'b0, 1'b0);
      tick();
    end
    desc_valid = 0;
    chk("t6_pre_abort", {ctrl_valid, fifo_level, timeout_err, cfg_err}, {1'b1, 3'd2, 1'b1, 1'b1});
    abort = 1;
    set_desc(8'h77, 8'h01, 8'h02, 1'b0, 1'b0);
    tick(); abort = 0; desc_valid = 0;
    chk("t6_post_abort", {ctrl_valid, fifo_level, timeout_err, cfg_err, busy}, 7'b0);
    chk("t6_layer_cnt_kept", layer_cnt, 8);
    tick();
    chk("t6_dropped_push", {ctrl_valid, fifo_level}, 4'b0);

    // Asynchronous reset in WAIT_FIN.
    ctrl_ready = 1;
    set_desc(8'h44, 8'h45, 8'h46, 1'b1, 1'b0);
    tick(); desc_valid = 0;
    tick(); tick();
    chk("t7_in_wait", {busy, ctrl_valid}, 2'b10);
    #2 rst = 1;
    #1;
    chk("t7_async_rst", {desc_ready, ctrl_valid, busy, layer_done, fifo_level, timeout_err, cfg_err},
        {1'b1, 8'b0});
    chk("t7_async_rst_cnt_fields", {layer_cnt, w_num_o, h_num_o, c_num_o, kernal_mode_o, bit_mode_o}, 42'b0);
    tick();
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
